// File: rtl/device_id_reader.sv
// Serial device-ID reader for a DNA_PORT-style primitive.
//
// Drives the primitive's slow clock, parallel-load and shift pins, shifts DATA_WIDTH bits in
// MSB-first and presents them left-aligned on id_data. One acquisition runs automatically after
// reset; further ones are requested with start. Optional build macro ID_READER_VERIFY_EN runs two
// passes per acquisition and reports whether they agree on id_match.
//
// Ports:
//   aclk      in   clock
//   aresetn   in   synchronous active-low reset
//   start     in   single-cycle re-read request (ignored while busy)
//   busy      out  acquisition in progress
//   valid     out  id_data holds a completed read
//   id_data   out  {id bits, (OUT_WIDTH-DATA_WIDTH) zeros}
//   id_match  out  pass comparison result (equals valid in the single-pass build)
//   dna_clk   out  primitive clock
//   dna_read  out  primitive parallel-load strobe
//   dna_shift out  primitive shift enable
//   dna_dout  in   primitive serial data out
module device_id_reader #(
   parameter int unsigned DATA_WIDTH   = 57,
   parameter int unsigned OUT_WIDTH    = 64,
   parameter int unsigned CLK_DIV_LOG2 = 5
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 start,
   output logic                 busy,
   output logic                 valid,
   output logic [OUT_WIDTH-1:0] id_data,
   output logic                 id_match,
   output logic                 dna_clk,
   output logic                 dna_read,
   output logic                 dna_shift,
   input  logic                 dna_dout
);

   localparam int unsigned CntW = CLK_DIV_LOG2 + 1;
   localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
   localparam int unsigned PadW = OUT_WIDTH - DATA_WIDTH;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [OUT_WIDTH-1:0]  id_q, id_d;
   logic                  busy_q, busy_d;
   logic                  valid_q, valid_d;
   logic                  read_q, read_d;
   logic                  shen_q, shen_d;
   logic                  pend_q, pend_d;

   logic [DATA_WIDTH-1:0] shift_nxt;
   logic [OUT_WIDTH-1:0]  id_nxt;
   logic                  sample;
   logic                  last_bit;

`ifdef ID_READER_VERIFY_EN
   logic                  pass_q, pass_d;
   logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
   logic                  match_q, match_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      id_d      = id_q;
      busy_d    = busy_q;
      valid_d   = valid_q;
      read_d    = read_q;
      shen_d    = shen_q;
      pend_d    = pend_q;
`ifdef ID_READER_VERIFY_EN
      pass_d    = pass_q;
      cmp_d     = cmp_q;
      match_d   = match_q;
`endif
      shift_nxt = {shift_q[DATA_WIDTH-2:0], dna_dout};
      id_nxt    = OUT_WIDTH'(shift_nxt) << PadW;
      // Sample point is the last cycle of each slow period, just before dna_clk falls.
      sample    = (cnt_q == {CntW{1'b1}});
      last_bit  = (bit_q == BitW'(DATA_WIDTH - 1));

      unique case (state_q)
         StIdle, StDone: begin
            cnt_d = '0;
            if (start || pend_q) begin
               state_d = StLoad;
               pend_d  = 1'b0;
               valid_d = 1'b0;
               busy_d  = 1'b1;
               read_d  = 1'b1;
               bit_d   = '0;
`ifdef ID_READER_VERIFY_EN
               pass_d  = 1'b0;
               match_d = 1'b0;
`endif
            end
         end
         StLoad, StShift: begin
            cnt_d = cnt_q + CntW'(1);
            if (sample) begin
               shift_d = shift_nxt;
               bit_d   = bit_q + BitW'(1);
               if (state_q == StLoad) begin
                  state_d = StShift;
                  read_d  = 1'b0;
                  shen_d  = 1'b1;
               end
               if (last_bit) begin
`ifdef ID_READER_VERIFY_EN
                  if (!pass_q) begin
                     // First pass done: keep it and restart the load immediately.
                     cmp_d   = shift_nxt;
                     pass_d  = 1'b1;
                     bit_d   = '0;
                     state_d = StLoad;
                     read_d  = 1'b1;
                     shen_d  = 1'b0;
                  end else begin
                     match_d = (cmp_q == shift_nxt);
                     pass_d  = 1'b0;
                     state_d = StDone;
                     shen_d  = 1'b0;
                     busy_d  = 1'b0;
                     valid_d = 1'b1;
                     id_d    = id_nxt;
                  end
`else
                  state_d = StDone;
                  shen_d  = 1'b0;
                  busy_d  = 1'b0;
                  valid_d = 1'b1;
                  id_d    = id_nxt;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         id_q    <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         read_q  <= 1'b0;
         shen_q  <= 1'b0;
         pend_q  <= 1'b1;
`ifdef ID_READER_VERIFY_EN
         pass_q  <= 1'b0;
         cmp_q   <= '0;
         match_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         read_q  <= read_d;
         shen_q  <= shen_d;
         pend_q  <= pend_d;
`ifdef ID_READER_VERIFY_EN
         pass_q  <= pass_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign valid     = valid_q;
   assign id_data   = id_q;
   assign dna_read  = read_q;
   assign dna_shift = shen_q;
   // Slow clock is the divider MSB straight from a flop, so it cannot glitch.
   assign dna_clk   = cnt_q[CntW-1];
`ifdef ID_READER_VERIFY_EN
   assign id_match  = match_q;
`else
   assign id_match  = valid_q;
`endif

endmodule

// File: tb/tb_device_id_reader.sv
module tb_device_id_reader;

   typedef struct {
      logic [63:0] id;
      logic        m;
      int          c0;
      int          lat;
   } exp_t;

`ifdef ID_READER_VERIFY_EN
   localparam int NPass = 2;
`else
   localparam int NPass = 1;
`endif
   localparam int SLat = NPass * 8 * 4 + 1;
   localparam int DLat = NPass * 57 * 64 + 1;
   localparam logic [56:0] DefId = 57'h1_2345_6789_ABCD_EF;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Small instance: 8 bits, 16-bit output, slow period 4
   logic        s_rstn, s_start, s_busy, s_valid, s_match, s_dclk, s_read, s_shift, s_dout;
   logic [15:0] s_data;
   logic [7:0]  s_id, s_reg;

   device_id_reader #(.DATA_WIDTH(8), .OUT_WIDTH(16), .CLK_DIV_LOG2(1)) u_small (
      .aclk(aclk), .aresetn(s_rstn), .start(s_start), .busy(s_busy), .valid(s_valid),
      .id_data(s_data), .id_match(s_match), .dna_clk(s_dclk), .dna_read(s_read),
      .dna_shift(s_shift), .dna_dout(s_dout)
   );

   always @(posedge s_dclk) begin
      if (s_read) s_reg <= s_id;
      else if (s_shift) s_reg <= {s_reg[6:0], 1'b0};
   end
   assign s_dout = s_reg[7];

   // Default-parameter instance
   logic        d_rstn, d_start, d_busy, d_valid, d_match, d_dclk, d_read, d_shift, d_dout;
   logic [63:0] d_data;
   logic [56:0] d_reg;

   device_id_reader u_def (
      .aclk(aclk), .aresetn(d_rstn), .start(d_start), .busy(d_busy), .valid(d_valid),
      .id_data(d_data), .id_match(d_match), .dna_clk(d_dclk), .dna_read(d_read),
      .dna_shift(d_shift), .dna_dout(d_dout)
   );

   always @(posedge d_dclk) begin
      if (d_read) d_reg <= DefId;
      else if (d_shift) d_reg <= {d_reg[55:0], 1'b0};
   end
   assign d_dout = d_reg[56];

   // Scoreboards and monitors
   exp_t s_q[$];
   exp_t d_q[$];
   logic s_valid_p = 1'b0, d_valid_p = 1'b0, s_dclk_p = 1'b0;
   int   s_rd_cyc = 0, s_rises = 0;

   always @(negedge aclk) begin
      exp_t e;
      if (s_valid && !s_valid_p) begin
         if (s_q.size() == 0) check_eq("s_unexpected_done", 64'd1, 64'd0);
         else begin
            e = s_q.pop_front();
            check_eq("s_id_data", 64'(s_data), e.id);
            check_eq("s_id_match", 64'(s_match), 64'(e.m));
            check_eq("s_latency", 64'(cyc - e.c0), 64'(e.lat));
         end
      end
      if (d_valid && !d_valid_p) begin
         if (d_q.size() == 0) check_eq("d_unexpected_done", 64'd1, 64'd0);
         else begin
            e = d_q.pop_front();
            check_eq("d_id_data", d_data, e.id);
            check_eq("d_id_match", 64'(d_match), 64'(e.m));
            check_eq("d_latency", 64'(cyc - e.c0), 64'(e.lat));
         end
      end
      if (s_read) s_rd_cyc <= s_rd_cyc + 1;
      if (s_dclk && !s_dclk_p) s_rises <= s_rises + 1;
      s_valid_p <= s_valid;
      d_valid_p <= d_valid;
      s_dclk_p  <= s_dclk;
   end

   task automatic push_s(input logic [15:0] id, input logic m);
      exp_t e;
      e.id = 64'(id); e.m = m; e.c0 = cyc; e.lat = SLat;
      s_q.push_back(e);
   endtask

   task automatic wait_s_valid(input int budget);
      int n = 0;
      while (!s_valid && n < budget) begin
         @(negedge aclk);
         n++;
      end
      if (!s_valid) check_eq("s_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rd0, ck0, n;
      exp_t e;
      s_rstn = 1'b0; s_start = 1'b0; s_id = 8'hA5;
      d_rstn = 1'b0; d_start = 1'b0;
      repeat (2) @(negedge aclk);
      s_start = 1'b1;                      // start during reset must be ignored
      @(negedge aclk);
      s_start = 1'b0;
      @(negedge aclk);
      check_eq("rst_status", 64'({s_busy, s_valid, s_match}), 64'd0);
      check_eq("rst_pins", 64'({s_dclk, s_read, s_shift}), 64'd0);
      check_eq("rst_id_data", 64'(s_data), 64'd0);

      // 1: auto-read after reset
      rd0 = s_rd_cyc; ck0 = s_rises;
      s_rstn = 1'b1;
      push_s(16'hA500, 1'b1);
      @(negedge aclk);
      check_eq("auto_busy", 64'(s_busy), 64'd1);
      wait_s_valid(200);
      @(negedge aclk);
      check_eq("load_cycles", 64'(s_rd_cyc - rd0), 64'(4 * NPass));
      check_eq("dclk_rises", 64'(s_rises - ck0), 64'(8 * NPass));
      check_eq("done_busy", 64'(s_busy), 64'd0);

      // 2: re-read from DONE with a new ID
      s_id = 8'h3C;
      s_start = 1'b1;
      push_s(16'h3C00, 1'b1);
      @(negedge aclk);
      s_start = 1'b0;
      check_eq("reread_valid_drop", 64'(s_valid), 64'd0);
      check_eq("reread_busy", 64'(s_busy), 64'd1);
      repeat (12) @(negedge aclk);
      check_eq("reread_hold_old", 64'(s_data), 64'hA500);
      wait_s_valid(200);
      @(negedge aclk);

      // 3: start while busy is ignored
      s_id = 8'h5A;
      ck0 = s_rises;
      s_start = 1'b1;
      push_s(16'h5A00, 1'b1);
      @(negedge aclk);
      s_start = 1'b0;
      repeat (9) @(negedge aclk);
      s_start = 1'b1;
      @(negedge aclk);
      s_start = 1'b0;
      wait_s_valid(200);
      repeat (80) @(negedge aclk);
      check_eq("busy_start_no_queue", 64'(s_busy), 64'd0);
      check_eq("busy_start_rises", 64'(s_rises - ck0), 64'(8 * NPass));

      // 4: reset in the middle of SHIFT (bit 4)
      s_id = 8'hA5;
      s_start = 1'b1;
      @(negedge aclk);
      s_start = 1'b0;
      repeat (17) @(negedge aclk);
      check_eq("mid_shift_active", 64'(s_shift), 64'd1);
      s_rstn = 1'b0;
      @(negedge aclk);
      check_eq("mid_rst_status", 64'({s_busy, s_valid, s_match}), 64'd0);
      check_eq("mid_rst_pins", 64'({s_dclk, s_read, s_shift}), 64'd0);
      check_eq("mid_rst_id_data", 64'(s_data), 64'd0);
      s_rstn = 1'b1;
      push_s(16'hA500, 1'b1);
      wait_s_valid(200);
      @(negedge aclk);

`ifdef ID_READER_VERIFY_EN
      // 6: ID changes between passes, then stable
      s_id = 8'h5A;
      s_start = 1'b1;
      push_s(16'h4A00, 1'b0);
      @(negedge aclk);
      s_start = 1'b0;
      n = 0;
      while (s_read && n < 50) begin
         @(negedge aclk);
         n++;
      end
      check_eq("pass1_load_end", 64'(s_read), 64'd0);
      s_id = 8'h4A;
      wait_s_valid(200);
      @(negedge aclk);
      s_start = 1'b1;
      push_s(16'h4A00, 1'b1);
      @(negedge aclk);
      s_start = 1'b0;
      wait_s_valid(200);
      @(negedge aclk);
`endif

      // 5: default parameters
      check_eq("d_rst_id_data", d_data, 64'd0);
      d_rstn = 1'b1;
      e.id = {DefId, 7'b0}; e.m = 1'b1; e.c0 = cyc; e.lat = DLat;
      d_q.push_back(e);
      n = 0;
      while (!d_valid && n < 8000) begin
         @(negedge aclk);
         n++;
      end
      if (!d_valid) check_eq("d_timeout", 64'd0, 64'd1);
      @(negedge aclk);

      check_eq("s_queue_empty", 64'(s_q.size()), 64'd0);
      check_eq("d_queue_empty", 64'(d_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/device_id_reader.md
Name: device_id_reader

Overview:
Parametrised serial device-ID reader.
- Drives a DNA_PORT-style primitive through external pins: slow clock, read, shift, serial data in.
- Reads DATA_WIDTH bits MSB-first and presents them left-aligned on a wide output.
- Re-read on request, with busy/valid status. The top-level wrapper instantiates the primitive.
- Runs automatically once after reset.

Parameters:
DATA_WIDTH, 57, number of ID bits shifted out of the primitive (>=2)
OUT_WIDTH, 64, width of id_data; must be >= DATA_WIDTH
CLK_DIV_LOG2, 5, slow clock period = 2^(CLK_DIV_LOG2+1) aclk cycles

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
start  in  1  single-cycle re-read request
busy  out  1  acquisition in progress
valid  out  1  id_data holds a completed read
id_data  out  OUT_WIDTH  {id bits, (OUT_WIDTH-DATA_WIDTH) zeros}
id_match  out  1  double-read comparison result (see Optional Feature)
dna_clk  out  1  primitive clock
dna_read  out  1  primitive parallel-load strobe
dna_shift  out  1  primitive shift enable
dna_dout  in  1  primitive serial data out

Behaviour:
- Interface: reset aresetn, synchronous, active-low; clock aclk. All outputs are registered.
- Reset values: busy=0, valid=0, id_data=0, id_match=0, dna_clk=0, dna_read=0, dna_shift=0. Divider counter=0. Bit counter=0. State=IDLE with a pending auto-start.
- States:
  - IDLE: start or pending auto-start -> LOAD; clears valid; busy=1 from the next cycle.
  - LOAD: dna_read=1 for one slow period.
  - SHIFT: dna_shift=1.
  - DONE: busy=0, valid=1.
- Divider: counter cnt[CLK_DIV_LOG2:0] increments every cycle in LOAD/SHIFT; held at 0 otherwise. dna_clk = cnt MSB, so its rising edge is mid-period.
- Sample point: cnt all-ones.
  - Shift dna_dout into the LSB of the shift register; MSB-first ordering.
  - Increment the bit counter.
  - The first sample is at the end of the LOAD period; there LOAD -> SHIFT, dna_read 1->0 and dna_shift 0->1 on the same edge.
- After the DATA_WIDTH-th sample:
  - -> DONE; dna_shift=0.
  - id_data <= {shift_reg, zeros} and valid=1, updated in the same cycle.
- Latency: start accepted at cycle 0 -> valid high at cycle DATA_WIDTH*2^(CLK_DIV_LOG2+1)+1.
- id_data holds its previous value throughout a re-read; it is only overwritten at completion.
- Boundary conditions:
  - start while busy: ignored; no queueing.
  - start in DONE: valid drops the next cycle, a new acquisition begins, and id_data keeps the old value until the new one completes.
  - start during the reset cycle: ignored; the auto-start still runs.
  - Reset mid-acquisition: immediate return to reset values; dna_read/dna_shift drop; auto-start is re-armed.
  - dna_clk never glitches: it only changes from the counter MSB.
- Without the feature, id_match = valid.

Optional Feature:
Macro ID_READER_VERIFY_EN.
- Defined: each acquisition runs two complete LOAD+SHIFT passes back-to-back; the pass-1 result is stored in a compare register.
  - At pass-2 completion, id_data <= pass-2 result and id_match <= (pass1 == pass2); valid=1.
  - Latency doubles: 2*DATA_WIDTH*2^(CLK_DIV_LOG2+1)+1.
  - busy stays high across both passes.
  - Reset or any mid-run condition discards pass 1.
- Undefined: single pass; id_match = valid; no compare register synthesised.

Test Plan:
Bench parameters unless noted: DATA_WIDTH=8, OUT_WIDTH=16, CLK_DIV_LOG2=1 (period 4), with a primitive model loaded with 0xA5.
1. Release reset -> auto-read: busy=1; valid=1 at cycle 33 after acquisition start; id_data=0xA500; dna_read high exactly 4 cycles; dna_clk rising edges=8.
2. Change model to 0x3C and pulse start in DONE -> valid=0 next cycle; id_data stays 0xA500 until completion, then 0x3C00.
3. Pulse start at cycle 10 of a busy acquisition -> ignored; only one completion; total of 8 dna_clk rising edges.
4. Assert aresetn=0 mid-SHIFT (bit 4) -> next cycle all outputs 0; after release a full auto-read returns 0xA500.
5. Defaults (57/64/5) with model 0x1_2345_6789_ABCD_EF -> valid at cycle 57*64+1=3649; id_data = {ID, 7'b0}.
6. ID_READER_VERIFY_EN, model flips one bit between passes -> valid at cycle 65, id_match=0; with a stable model, id_match=1.
